// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command front end.
//   - rx_state_e : receiver FSM states
//   - CMD_*      : ASCII characters recognised by the command decoder
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] CMD_RUN  = 8'h72; // 'r'
    localparam logic [7:0] CMD_CLR  = 8'h6C; // 'l'
    localparam logic [7:0] CMD_UP   = 8'h75; // 'u'
    localparam logic [7:0] CMD_DOWN = 8'h64; // 'd'
    localparam logic [7:0] CMD_SW0  = 8'h30; // '0'
    localparam logic [7:0] CMD_SW1  = 8'h31; // '1'
    localparam logic [7:0] CMD_SW2  = 8'h32; // '2'

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver driven by an external oversampling strobe.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   rx        - asynchronous serial line (idles high)
//   b_tick    - one-clk strobe at OVS x baud
//   rx_data   - last byte received with a valid stop bit
//   rx_done   - one-clk pulse when rx_data is updated
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 b_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 rx_s;

    assign rx_s    = sync_q[1];
    assign rx_data = data_q;
    assign rx_done = done_q;

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rx};
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Start edge is taken on any clk, not just tick clks, so the
                // half-bit count below lines up within one tick of the edge.
                if (!rx_s) begin
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (b_tick) begin
                    if (tick_q == TW'(OVS / 2 - 1)) begin
                        if (!rx_s) begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE; // too short to be a start bit
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (tick_q == TW'(OVS - 1)) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (b_tick) begin
                    if (tick_q == TW'(OVS - 1)) begin
                        // Framing error drops the byte silently.
                        if (rx_s) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command front end: receives characters and turns them into button
// pulses and toggled switch levels for the stopwatch/watch control logic.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   rx, b_tick          - serial line and OVS x baud strobe
//   rx_data, rx_done    - last framed byte and its one-clk strobe
//   uart_btn_{r,l,u,d}  - one-clk pulses for 'r','l','u','d'
//   uart_sw_*           - levels toggled by '0','1','2'
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       b_tick,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       uart_btn_r,
    output logic       uart_btn_l,
    output logic       uart_btn_u,
    output logic       uart_btn_d,
    output logic       uart_sw_mode,
    output logic       uart_sw_sel_mode,
    output logic       uart_sw_sel_display
);

    uart_rx_core #(
        .OVS       (OVS),
        .DATA_BITS (DATA_BITS)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .b_tick  (b_tick),
        .rx_data (rx_data),
        .rx_done (rx_done)
    );

    // {r, l, u, d} and {mode, sel_mode, sel_display}
    logic [3:0] btn_q, btn_d;
    logic [2:0] sw_q, sw_d;

    always_comb begin
        btn_d = '0;   // pulses last only the clk after a matching rx_done
        sw_d  = sw_q;
        if (rx_done) begin
            case (rx_data)
                CMD_RUN:  btn_d[3] = 1'b1;
                CMD_CLR:  btn_d[2] = 1'b1;
                CMD_UP:   btn_d[1] = 1'b1;
                CMD_DOWN: btn_d[0] = 1'b1;
                CMD_SW0:  sw_d[2]  = ~sw_q[2];
                CMD_SW1:  sw_d[1]  = ~sw_q[1];
                CMD_SW2:  sw_d[0]  = ~sw_q[0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '0;
            sw_q  <= '0;
        end else begin
            btn_q <= btn_d;
            sw_q  <= sw_d;
        end
    end

    assign {uart_btn_r, uart_btn_l, uart_btn_u, uart_btn_d} = btn_q;
    assign {uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display} = sw_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       b_tick = 1'b0;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       uart_btn_r, uart_btn_l, uart_btn_u, uart_btn_d;
    logic       uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display;

    int total = 0;
    int bad   = 0;

    // monitor state
    int         done_cnt = 0;
    int         lat_err  = 0;
    int         r_hi = 0, l_hi = 0, u_hi = 0, d_hi = 0;
    logic [7:0] last_data = 8'h00;
    bit         prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] btn_log[$];

    uart_cmd_decoder #(.OVS(16), .DATA_BITS(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx                  (rx),
        .b_tick              (b_tick),
        .rx_data             (rx_data),
        .rx_done             (rx_done),
        .uart_btn_r          (uart_btn_r),
        .uart_btn_l          (uart_btn_l),
        .uart_btn_u          (uart_btn_u),
        .uart_btn_d          (uart_btn_d),
        .uart_sw_mode        (uart_sw_mode),
        .uart_sw_sel_mode    (uart_sw_sel_mode),
        .uart_sw_sel_display (uart_sw_sel_display)
    );

    always #5 clk = ~clk;

    // b_tick: one clk high every 4 clks
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            b_tick = (div == 3);
            div    = (div == 3) ? 0 : div + 1;
        end
    end

    // Sampled just after each active edge. Any button must be the one
    // named by the byte whose rx_done was seen on the previous cycle.
    initial begin : monitor
        logic [3:0] exp_btn;
        forever begin
            @(posedge clk);
            #1;
            exp_btn = 4'b0000;
            if (prev_done) begin
                exp_btn[3] = (prev_data == 8'h72);
                exp_btn[2] = (prev_data == 8'h6C);
                exp_btn[1] = (prev_data == 8'h75);
                exp_btn[0] = (prev_data == 8'h64);
            end
            if ({uart_btn_r, uart_btn_l, uart_btn_u, uart_btn_d} !== exp_btn) lat_err++;
            if (rx_done === 1'b1) begin
                done_cnt++;
                last_data = rx_data;
            end
            if (uart_btn_r === 1'b1) begin r_hi++; btn_log.push_back(8'h72); end
            if (uart_btn_l === 1'b1) begin l_hi++; btn_log.push_back(8'h6C); end
            if (uart_btn_u === 1'b1) begin u_hi++; btn_log.push_back(8'h75); end
            if (uart_btn_d === 1'b1) begin d_hi++; btn_log.push_back(8'h64); end
            prev_done = (rx_done === 1'b1) && !rst;
            prev_data = rx_data;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (b_tick !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_ticks);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
        rx = stop_val;
        wait_ticks(stop_ticks);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
        total++; if ({uart_btn_r, uart_btn_l, uart_btn_u, uart_btn_d} !== 4'b0000) begin
            bad++; $display("FAIL reset_btns got=%b exp=0000", {uart_btn_r, uart_btn_l, uart_btn_u, uart_btn_d}); end
        total++; if ({uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display} !== 3'b000) begin
            bad++; $display("FAIL reset_sws got=%b exp=000", {uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display}); end
    endtask

    task automatic test_idle();
        int d0;
        d0 = done_cnt;
        wait_ticks(320);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL idle_done got=%0d exp=0", done_cnt - d0); end
        total++; if (r_hi + l_hi + u_hi + d_hi !== 0) begin bad++; $display("FAIL idle_btns got=%0d exp=0", r_hi + l_hi + u_hi + d_hi); end
        total++; if ({uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display} !== 3'b000) begin
            bad++; $display("FAIL idle_sws got=%b exp=000", {uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display}); end
    endtask

    task automatic test_run();
        int d0, r0;
        d0 = done_cnt; r0 = r_hi;
        send_byte(8'h72, 1'b1, 16);
        wait_ticks(8);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL run_done got=%0d exp=1", done_cnt - d0); end
        total++; if (rx_data !== 8'h72) begin bad++; $display("FAIL run_rx_data got=%h exp=72", rx_data); end
        total++; if (r_hi - r0 !== 1) begin bad++; $display("FAIL run_btn_r_cycles got=%0d exp=1", r_hi - r0); end
        total++; if (l_hi + u_hi + d_hi !== 0) begin bad++; $display("FAIL run_other_btns got=%0d exp=0", l_hi + u_hi + d_hi); end
        total++; if (lat_err !== 0) begin bad++; $display("FAIL run_btn_timing got=%0d exp=0", lat_err); end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        btn_log.delete();
        send_byte(8'h6C, 1'b1, 16);
        send_byte(8'h75, 1'b1, 16);
        send_byte(8'h64, 1'b1, 16);
        wait_ticks(8);
        total++; if (done_cnt - d0 !== 3) begin bad++; $display("FAIL b2b_done got=%0d exp=3", done_cnt - d0); end
        total++; if (btn_log.size() !== 3) begin bad++; $display("FAIL b2b_pulse_count got=%0d exp=3", btn_log.size()); end
        total++; if (btn_log[0] !== 8'h6C) begin bad++; $display("FAIL b2b_first got=%h exp=6c", btn_log[0]); end
        total++; if (btn_log[1] !== 8'h75) begin bad++; $display("FAIL b2b_second got=%h exp=75", btn_log[1]); end
        total++; if (btn_log[2] !== 8'h64) begin bad++; $display("FAIL b2b_third got=%h exp=64", btn_log[2]); end
        total++; if (rx_data !== 8'h64) begin bad++; $display("FAIL b2b_rx_data got=%h exp=64", rx_data); end
        total++; if (lat_err !== 0) begin bad++; $display("FAIL b2b_btn_timing got=%0d exp=0", lat_err); end
    endtask

    task automatic test_switches();
        send_byte(8'h30, 1'b1, 16);
        total++; if (uart_sw_mode !== 1'b1) begin bad++; $display("FAIL sw_mode_first got=%b exp=1", uart_sw_mode); end
        send_byte(8'h30, 1'b1, 16);
        total++; if (uart_sw_mode !== 1'b0) begin bad++; $display("FAIL sw_mode_second got=%b exp=0", uart_sw_mode); end
        send_byte(8'h31, 1'b1, 16);
        send_byte(8'h32, 1'b1, 16);
        wait_ticks(4);
        total++; if ({uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display} !== 3'b011) begin
            bad++; $display("FAIL sw_final got=%b exp=011", {uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display}); end
    endtask

    task automatic test_glitch();
        int d0, b0;
        d0 = done_cnt; b0 = r_hi + l_hi + u_hi + d_hi;
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(40);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
        send_byte(8'h41, 1'b1, 16);
        wait_ticks(8);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL upper_a_done got=%0d exp=1", done_cnt - d0); end
        total++; if (last_data !== 8'h41) begin bad++; $display("FAIL upper_a_rx_data got=%h exp=41", last_data); end
        total++; if (r_hi + l_hi + u_hi + d_hi - b0 !== 0) begin bad++; $display("FAIL upper_a_btns got=%0d exp=0", r_hi + l_hi + u_hi + d_hi - b0); end
        total++; if ({uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display} !== 3'b011) begin
            bad++; $display("FAIL upper_a_sws got=%b exp=011", {uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display}); end
    endtask

    task automatic test_frame_err_and_reset();
        int d0, r0;
        logic [7:0] r_chr;
        r_chr = 8'h72;
        d0 = done_cnt; r0 = r_hi;
        // stop bit low long enough to be sampled, released before a false start can lock on
        send_byte(8'h75, 1'b0, 10);
        wait_ticks(30);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL frame_err_done got=%0d exp=0", done_cnt - d0); end
        // 'r' frame cut by reset after start + 4 data bits
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = r_chr[i];
            wait_ticks(16);
        end
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(160);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL mid_reset_done got=%0d exp=0", done_cnt - d0); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_reset_rx_data got=%h exp=00", rx_data); end
        total++; if ({uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display} !== 3'b000) begin
            bad++; $display("FAIL mid_reset_sws got=%b exp=000", {uart_sw_mode, uart_sw_sel_mode, uart_sw_sel_display}); end
        total++; if (r_hi - r0 !== 0) begin bad++; $display("FAIL mid_reset_btn_r got=%0d exp=0", r_hi - r0); end
        send_byte(8'h72, 1'b1, 16);
        wait_ticks(8);
        total++; if (r_hi - r0 !== 1) begin bad++; $display("FAIL clean_r_btn got=%0d exp=1", r_hi - r0); end
        total++; if (rx_data !== 8'h72) begin bad++; $display("FAIL clean_r_rx_data got=%h exp=72", rx_data); end
        total++; if (lat_err !== 0) begin bad++; $display("FAIL final_btn_timing got=%0d exp=0", lat_err); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_run();
        test_back_to_back();
        test_switches();
        test_glitch();
        test_frame_err_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
